// File: rtl/div_seq_nbit_pkg.sv
// Shared types and helpers for the sequential 2N/N divider.
// abs_n works on a fixed wide container; callers sign-extend into it (supports N <= 63).
package div_seq_nbit_pkg;

   localparam int unsigned ST_W  = 2;
   localparam int unsigned ABS_W = 128;

   typedef enum logic [ST_W-1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] x);
      return x[ABS_W-1] ? -x : x;
   endfunction

endpackage

// File: rtl/div_seq_nbit_if.sv
// Handshake and operand/result bundle between the ALU op decoder and the divider.
interface div_seq_nbit_if #(parameter int unsigned N = 16);

   logic           start;
   logic           signed_op;
   logic [2*N-1:0] a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [N-1:0]   cat;
   logic [N-1:0]   rest;
   logic           div_zero;
   logic           ovf;

   modport master (
      output start, signed_op, a, b,
      input  busy, done, cat, rest, div_zero, ovf
   );

   modport slave (
      input  start, signed_op, a, b,
      output busy, done, cat, rest, div_zero, ovf
   );

endinterface

// File: rtl/div_seq_nbit_step.sv
// One combinational non-restoring division step on the (A, Q) pair with divisor M.
module div_nr_step #(
   parameter int unsigned N = 16
) (
   input  logic [N:0]   a_i,
   input  logic [N-1:0] q_i,
   input  logic [N-1:0] m_i,
   output logic [N:0]   a_o,
   output logic [N-1:0] q_o
);

   logic [N:0] shifted;

   // Sign is decided on the stored A; the shifted value may wrap but the result lands in range.
   always_comb begin
      shifted = {a_i[N-1:0], q_i[N-1]};
      if (a_i[N]) begin
         a_o = shifted + {1'b0, m_i};
      end else begin
         a_o = shifted - {1'b0, m_i};
      end
      q_o = {q_i[N-2:0], ~a_o[N]};
   end

endmodule

// File: rtl/div_seq_nbit.sv
// Multicycle 2N/N divider, one quotient bit per clock, optional two's-complement mode.
// Operands are divided as magnitudes; signs and exception flags are applied in FIX.
module div_seq_nbit
   import div_seq_nbit_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst,
   div_seq_nbit_if.slave bus
);

   localparam int unsigned  CW   = $clog2(N + 1);
   localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

   state_e state_q, state_d;
   logic   busy, load, step_en, fix_en;

   logic [ABS_W-1:0] a_ext, b_ext;
   logic [2*N-1:0]   mag_a;
   logic [N-1:0]     mag_b;
   logic             exc_in;

   logic [N:0]   acc_q, acc_nx;
   logic [N-1:0] quo_q, quo_nx, m_q;
   logic [CW-1:0] count_q;
   logic          sgnq_q, sgnr_q, sop_q, dz_q, exc_q;

   logic [N-1:0] rem_mag, cat_d, rest_d, cat_q, rest_q;
   logic         divz_d, ovf_d, divz_q, ovf_q, done_q, sovf;

   always_comb begin
      a_ext  = {{(ABS_W-2*N){bus.signed_op & bus.a[2*N-1]}}, bus.a};
      b_ext  = {{(ABS_W-N){bus.signed_op & bus.b[N-1]}}, bus.b};
      mag_a  = (2*N)'(abs_n(a_ext));
      mag_b  = N'(abs_n(b_ext));
      exc_in = (mag_b == '0) || (mag_a[2*N-1:N] >= mag_b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = exc_in ? FIX : CALC;
         CALC:    if (count_q == CW'(N - 1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      load    = (state_q == IDLE) && bus.start;
      step_en = (state_q == CALC);
      fix_en  = (state_q == FIX);
   end

   div_nr_step #(.N(N)) u_step (
      .a_i (acc_q),
      .q_i (quo_q),
      .m_i (m_q),
      .a_o (acc_nx),
      .q_o (quo_nx)
   );

   // On the div-by-zero path Q still holds |a| low half, so re-signing it recovers raw a[N-1:0].
   always_comb begin
      rem_mag = acc_q[N] ? (acc_q[N-1:0] + m_q) : acc_q[N-1:0];
      sovf    = sop_q && (sgnq_q ? (quo_q > HALF) : (quo_q >= HALF));
      cat_d   = sgnq_q ? -quo_q : quo_q;
      rest_d  = sgnr_q ? -rem_mag : rem_mag;
      divz_d  = 1'b0;
      ovf_d   = 1'b0;
      if (dz_q) begin
         cat_d  = '1;
         rest_d = sgnr_q ? -quo_q : quo_q;
         divz_d = 1'b1;
      end else if (exc_q || sovf) begin
         cat_d  = '1;
         rest_d = '0;
         ovf_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         quo_q   <= '0;
         m_q     <= '0;
         count_q <= '0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
         sop_q   <= 1'b0;
         dz_q    <= 1'b0;
         exc_q   <= 1'b0;
         cat_q   <= '0;
         rest_q  <= '0;
         divz_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= fix_en;
         if (load) begin
            acc_q   <= {1'b0, mag_a[2*N-1:N]};
            quo_q   <= mag_a[N-1:0];
            m_q     <= mag_b;
            count_q <= '0;
            sgnq_q  <= bus.signed_op & (bus.a[2*N-1] ^ bus.b[N-1]);
            sgnr_q  <= bus.signed_op & bus.a[2*N-1];
            sop_q   <= bus.signed_op;
            dz_q    <= (mag_b == '0);
            exc_q   <= exc_in;
         end else if (step_en) begin
            acc_q   <= acc_nx;
            quo_q   <= quo_nx;
            count_q <= count_q + CW'(1);
         end else if (fix_en) begin
            cat_q  <= cat_d;
            rest_q <= rest_d;
            divz_q <= divz_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.cat      = cat_q;
   assign bus.rest     = rest_q;
   assign bus.div_zero = divz_q;
   assign bus.ovf      = ovf_q;

endmodule
